// File: rtl/kbd_pkg.sv
// Shared definitions for the PS/2 set-2 scancode decoder: FSM encoding,
// prefix/modifier scancodes and the make-code to ASCII translation.
package kbd_pkg;

    typedef logic [1:0] kbd_state_t;

    localparam kbd_state_t ST_IDLE   = 2'd0;
    localparam kbd_state_t ST_ACK    = 2'd1;
    localparam kbd_state_t ST_WAIT   = 2'd2;
    localparam kbd_state_t ST_DECODE = 2'd3;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    // Returns 0x00 for any code with no printable/control mapping.
    function automatic logic [7:0] sc_to_ascii(input logic [7:0] code, input logic upper);
        logic [7:0] letter;
        logic [7:0] other;
        letter = 8'h00;
        other  = 8'h00;
        case (code)
            8'h1C: letter = 8'h61;
            8'h32: letter = 8'h62;
            8'h21: letter = 8'h63;
            8'h23: letter = 8'h64;
            8'h24: letter = 8'h65;
            8'h2B: letter = 8'h66;
            8'h34: letter = 8'h67;
            8'h33: letter = 8'h68;
            8'h43: letter = 8'h69;
            8'h3B: letter = 8'h6A;
            8'h42: letter = 8'h6B;
            8'h4B: letter = 8'h6C;
            8'h3A: letter = 8'h6D;
            8'h31: letter = 8'h6E;
            8'h44: letter = 8'h6F;
            8'h4D: letter = 8'h70;
            8'h15: letter = 8'h71;
            8'h2D: letter = 8'h72;
            8'h1B: letter = 8'h73;
            8'h2C: letter = 8'h74;
            8'h3C: letter = 8'h75;
            8'h2A: letter = 8'h76;
            8'h1D: letter = 8'h77;
            8'h22: letter = 8'h78;
            8'h35: letter = 8'h79;
            8'h1A: letter = 8'h7A;
            8'h45: other  = 8'h30;
            8'h16: other  = 8'h31;
            8'h1E: other  = 8'h32;
            8'h26: other  = 8'h33;
            8'h25: other  = 8'h34;
            8'h2E: other  = 8'h35;
            8'h36: other  = 8'h36;
            8'h3D: other  = 8'h37;
            8'h3E: other  = 8'h38;
            8'h46: other  = 8'h39;
            8'h29: other  = 8'h20;
            8'h5A: other  = 8'h0D;
            8'h66: other  = 8'h08;
            default: ;
        endcase
        if (letter != 8'h00) begin
            return upper ? (letter - 8'h20) : letter;
        end
        return other;
    endfunction

endpackage

// File: rtl/kbd_fifo.sv
// First-word-fall-through synchronous FIFO; head reads 0 when empty.
// A push into a full FIFO only succeeds when a pop frees a slot in the same cycle.
module kbd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             fclk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic             drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;
    assign dout    = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge fclk or negedge rst) begin
        if (!rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/kbd_scan_decoder.sv
// PS/2 set-2 scancode stream to ASCII FIFO: receiver handshake, prefix and
// modifier tracking, translation and overflow reporting.
//   state  | meaning
//   IDLE   | wait for kb_ready, latch byte, raise kb_rdn
//   ACK    | drop kb_rdn
//   WAIT   | wait for receiver to clear kb_ready
//   DECODE | update flags, push translated character
module kbd_scan_decoder
    import kbd_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic       fclk,
    input  logic       rst,
    input  logic       kb_ready,
    input  logic [7:0] kb_code,
    output logic       kb_rdn,
    input  logic       cpu_rd,
    output logic [7:0] ascii,
    output logic       fifo_empty,
    output logic       fifo_full,
    output logic       overflow
);

    kbd_state_t state_q, state_d;
    logic [7:0] code_q, code_d;
    logic       kb_rdn_q, kb_rdn_d;
    logic       brk_q, brk_d;
    logic       ext_q, ext_d;
    logic       shift_q, shift_d;
    logic       caps_q, caps_d;
    logic       overflow_q, overflow_d;
    logic       push, drop;
    logic [7:0] xlat;

    assign xlat     = sc_to_ascii(code_q, shift_q ^ caps_q);
    assign kb_rdn   = kb_rdn_q;
    assign overflow = overflow_q;

    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        kb_rdn_d   = 1'b0;
        brk_d      = brk_q;
        ext_d      = ext_q;
        shift_d    = shift_q;
        caps_d     = caps_q;
        overflow_d = overflow_q | drop;
        push       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (kb_ready) begin
                    code_d   = kb_code;
                    kb_rdn_d = 1'b1;
                    state_d  = ST_ACK;
                end
            end
            ST_ACK: state_d = ST_WAIT;
            ST_WAIT: begin
                if (!kb_ready) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = ST_IDLE;
                if (code_q == SC_EXT) begin
                    ext_d = 1'b1;
                end else if (code_q == SC_BRK) begin
                    brk_d = 1'b1;
                end else begin
                    // Extended keys (arrows, right ctrl/alt...) produce nothing here.
                    if (!ext_q) begin
                        if (code_q == SC_LSHIFT || code_q == SC_RSHIFT) begin
                            shift_d = !brk_q;
                        end else if (code_q == SC_CAPS) begin
                            if (!brk_q) begin
                                caps_d = !caps_q;
                            end
                        end else if (!brk_q && xlat != 8'h00) begin
                            push = 1'b1;
                        end
                    end
                    brk_d = 1'b0;
                    ext_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge fclk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            code_q     <= 8'h00;
            kb_rdn_q   <= 1'b0;
            brk_q      <= 1'b0;
            ext_q      <= 1'b0;
            shift_q    <= 1'b0;
            caps_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            kb_rdn_q   <= kb_rdn_d;
            brk_q      <= brk_d;
            ext_q      <= ext_d;
            shift_q    <= shift_d;
            caps_q     <= caps_d;
            overflow_q <= overflow_d;
        end
    end

    kbd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .fclk  (fclk),
        .rst   (rst),
        .push  (push),
        .din   (xlat),
        .pop   (cpu_rd),
        .dout  (ascii),
        .empty (fifo_empty),
        .full  (fifo_full),
        .drop  (drop)
    );

endmodule

// File: tb/tb_kbd_scan_decoder.sv
// Scoreboard bench for kbd_scan_decoder: a keyboard-level reference model
// queues expected characters; a monitor pops the DUT FIFO and compares.
module tb_kbd_scan_decoder;

    localparam int DEPTH = 8;

    logic       fclk = 1'b0;
    logic       rst = 1'b0;
    logic       kb_ready = 1'b0;
    logic [7:0] kb_code = 8'h00;
    logic       kb_rdn;
    logic       cpu_rd;
    logic [7:0] ascii;
    logic       fifo_empty, fifo_full, overflow;
    logic       mon_rd = 1'b0;
    logic       man_rd = 1'b0;

    assign cpu_rd = mon_rd | man_rd;

    always #5 fclk = ~fclk;

    kbd_scan_decoder #(.FIFO_DEPTH(DEPTH)) dut (
        .fclk       (fclk),
        .rst        (rst),
        .kb_ready   (kb_ready),
        .kb_code    (kb_code),
        .kb_rdn     (kb_rdn),
        .cpu_rd     (cpu_rd),
        .ascii      (ascii),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .overflow   (overflow)
    );

    int total = 0;
    int bad = 0;

    // Keyboard-level reference model
    bit         m_brk, m_ext, m_shift, m_caps, exp_ovf;
    bit         mon_en = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] letter_map[logic [7:0]];
    logic [7:0] digit_map[logic [7:0]];
    logic [7:0] pre_empty;
    logic [7:0] letter_codes[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                     8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                     8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                     8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digit_codes[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                    8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_char(input logic [7:0] b, input bit up);
        if (letter_map.exists(b)) return up ? letter_map[b] - 8'd32 : letter_map[b];
        if (digit_map.exists(b)) return digit_map[b];
        if (b == 8'h29) return 8'h20;
        if (b == 8'h5A) return 8'h0D;
        if (b == 8'h66) return 8'h08;
        return 8'h00;
    endfunction

    task automatic model_byte(input logic [7:0] b, input bit pop_same);
        logic [7:0] ch;
        ch = 8'h00;
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            if (!m_ext) begin
                if (b == 8'h12 || b == 8'h59) m_shift = !m_brk;
                else if (b == 8'h58) begin
                    if (!m_brk) m_caps = !m_caps;
                end else if (!m_brk) ch = ref_char(b, m_shift ^ m_caps);
            end
            m_brk = 1'b0;
            m_ext = 1'b0;
        end
        if (pop_same && exp_q.size() > 0) void'(exp_q.pop_front());
        if (ch != 8'h00) begin
            if (!pop_same && !mon_en && exp_q.size() == DEPTH) exp_ovf = 1'b1;
            else exp_q.push_back(ch);
        end
    endtask

    task automatic model_reset();
        m_brk = 0; m_ext = 0; m_shift = 0; m_caps = 0; exp_ovf = 0;
        exp_q.delete();
    endtask

    task automatic wait_rdn(input string nm);
        int n;
        n = 0;
        do begin
            @(posedge fclk); #1;
            n++;
        end while (!kb_rdn && n < 20);
        if (!kb_rdn) begin
            total++;
            bad++;
            $display("FAIL %s: kb_rdn timeout got 0 expected 1", nm);
        end
    endtask

    // Receiver behaviour: clear data_ready on the edge after kb_rdn is seen.
    task automatic send_byte(input logic [7:0] b, input bit rd_at_dec);
        model_byte(b, rd_at_dec);
        kb_code  = b;
        kb_ready = 1'b1;
        wait_rdn("send_rdn");
        @(posedge fclk); #1;
        kb_ready = 1'b0;
        chk("rdn_one_cycle", kb_rdn, 0);
        @(posedge fclk); #1;
        pre_empty = {7'd0, fifo_empty};
        if (rd_at_dec) man_rd = 1'b1;
        @(posedge fclk); #1;
        man_rd = 1'b0;
    endtask

    task automatic pop_one(input string nm, input logic [7:0] want);
        chk(nm, ascii, want);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        man_rd = 1'b1;
        @(posedge fclk); #1;
        man_rd = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !fifo_empty) && n < 200) begin
            @(posedge fclk);
            n++;
        end
        repeat (2) @(posedge fclk);
        #1;
        chk("drain_left", exp_q.size(), 0);
        chk("drain_empty", fifo_empty, 1);
    endtask

    // Monitor: pop whenever the DUT presents a character and compare to the scoreboard.
    initial begin
        forever begin
            @(negedge fclk);
            if (mon_en && rst && !fifo_empty) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL mon_unexpected: got %0h expected none", ascii);
                end else begin
                    chk("mon_ascii", ascii, exp_q.pop_front());
                end
                mon_rd = 1'b1;
            end else begin
                mon_rd = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int r;
        for (int i = 0; i < 26; i++) letter_map[letter_codes[i]] = 8'h61 + 8'(i);
        for (int i = 0; i < 10; i++) digit_map[digit_codes[i]] = 8'h30 + 8'(i);
        model_reset();

        // Reset values
        repeat (3) @(posedge fclk);
        #1;
        chk("rst_rdn", kb_rdn, 0);
        chk("rst_empty", fifo_empty, 1);
        chk("rst_full", fifo_full, 0);
        chk("rst_ascii", ascii, 8'h00);
        chk("rst_ovf", overflow, 0);
        @(negedge fclk);
        rst = 1'b1;
        @(posedge fclk); #1;

        // Single make code, latency and pop
        send_byte(8'h1C, 0);
        chk("lat_empty_edge3", pre_empty, 1);
        chk("lat_empty_edge4", fifo_empty, 0);
        pop_one("lat_ascii", 8'h61);
        chk("pop_empty", fifo_empty, 1);
        chk("pop_ascii0", ascii, 8'h00);

        // Shift make/break
        send_byte(8'h12, 0); send_byte(8'h1C, 0);
        send_byte(8'hF0, 0); send_byte(8'h12, 0); send_byte(8'h1C, 0);
        pop_one("shift_up", 8'h41);
        pop_one("shift_rel", 8'h61);
        chk("shift_empty", fifo_empty, 1);

        // Caps toggles, break ignored; shift cancels caps for letters, not digits
        send_byte(8'h58, 0); send_byte(8'hF0, 0); send_byte(8'h58, 0);
        send_byte(8'h12, 0); send_byte(8'h1C, 0); send_byte(8'h16, 0);
        send_byte(8'hF0, 0); send_byte(8'h12, 0); send_byte(8'h1C, 0);
        pop_one("caps_shift_a", 8'h61);
        pop_one("caps_digit", 8'h31);
        pop_one("caps_only_A", 8'h41);
        send_byte(8'h58, 0);

        // Extended codes ignored
        send_byte(8'hE0, 0); send_byte(8'h1C, 0);
        send_byte(8'hE0, 0); send_byte(8'hF0, 0); send_byte(8'h1C, 0);
        chk("ext_empty", fifo_empty, 1);
        send_byte(8'h1C, 0);
        pop_one("ext_after", 8'h61);
        chk("ext_after_empty", fifo_empty, 1);

        // Overflow and push+pop while full
        for (int i = 0; i < 9; i++) send_byte(8'h29, 0);
        chk("ovf_full", fifo_full, 1);
        chk("ovf_flag", overflow, 1);
        chk("ovf_model", overflow, exp_ovf);
        chk("ovf_head", ascii, 8'h20);
        send_byte(8'h1C, 1);
        chk("pp_full", fifo_full, 1);
        chk("pp_ovf", overflow, 1);
        mon_en = 1'b1;
        drain();
        mon_en = 1'b0;
        chk("ovf_sticky", overflow, 1);

        // Reset mid-handshake while in WAIT
        send_byte(8'h12, 0);
        send_byte(8'h29, 0);
        kb_code  = 8'h1C;
        kb_ready = 1'b1;
        wait_rdn("rst_rdn_wait");
        @(posedge fclk); #1;
        @(posedge fclk); #1;
        rst = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_rdn", kb_rdn, 0);
        chk("mid_rst_empty", fifo_empty, 1);
        chk("mid_rst_full", fifo_full, 0);
        chk("mid_rst_ascii", ascii, 8'h00);
        chk("mid_rst_ovf", overflow, 0);
        @(negedge fclk);
        rst = 1'b1;
        model_byte(8'h1C, 0);
        wait_rdn("post_rst_rdn");
        @(posedge fclk); #1;
        kb_ready = 1'b0;
        repeat (2) @(posedge fclk);
        #1;
        pop_one("post_rst_char", 8'h61);

        // Randomised stream against the reference model
        mon_en = 1'b1;
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 99);
            if (r < 8) b = 8'hE0;
            else if (r < 16) b = 8'hF0;
            else if (r < 24) b = ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59;
            else if (r < 28) b = 8'h58;
            else if (r < 75) b = letter_codes[$urandom_range(0, 25)];
            else if (r < 87) b = digit_codes[$urandom_range(0, 9)];
            else if (r < 93) begin
                r = $urandom_range(0, 2);
                b = (r == 0) ? 8'h29 : (r == 1) ? 8'h5A : 8'h66;
            end else b = 8'($urandom_range(0, 255));
            repeat ($urandom_range(0, 3)) @(posedge fclk);
            #1;
            send_byte(b, 0);
        end
        drain();
        chk("rand_ovf", overflow, exp_ovf);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/kbd_scan_decoder.md
# kbd_scan_decoder

Converts the PS/2 set-2 scancode byte stream from the keyboard receiver into ASCII characters queued for the CPU. Sits directly downstream of the receiver. It consumes each scancode via the receiver's `data_ready`/`rdn` handshake, tracks break/extended prefixes and shift/caps state, translates make codes, and buffers results in a small FIFO read by the CPU bus.

## Interface
- `FIFO_DEPTH`, default 8: ASCII FIFO entries; must be a power of 2, minimum 2.
- `fclk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-low.
- `kb_ready`  in  1  receiver's `data_ready`; high while a new scancode is held.
- `kb_code`  in  8  receiver's `scancode`; valid while `kb_ready`=1.
- `kb_rdn`  out  1  one-cycle acknowledge to the receiver; the receiver clears `data_ready` on the next edge.
- `cpu_rd`  in  1  pop request; one entry per cycle in which it is high.
- `ascii`  out  8  FIFO head (first-word fall-through); 0x00 when empty.
- `fifo_empty`  out  1  FIFO holds no entries.
- `fifo_full`  out  1  FIFO holds `FIFO_DEPTH` entries.
- `overflow`  out  1  sticky; a character was dropped because the FIFO was full.

## Operation
- States:
  - IDLE: when `kb_ready`=1, latch `kb_code`, set `kb_rdn`<=1, go to ACK.
  - ACK: `kb_rdn`<=0, go to WAIT.
  - WAIT: stay until `kb_ready`=0, then go to DECODE.
  - DECODE: act on the latched byte, then go to IDLE.
- Prefix bytes:
  - 0xE0 sets `ext`.
  - 0xF0 sets `brk`.
  - Neither pushes a character, and neither clears the other flag.
- Any other byte clears both `brk` and `ext` after it is processed.
- Modifiers (only when `ext`=0):
  - 0x12 or 0x59: `shift` <= !`brk`.
  - 0x58 with `brk`=0: toggle `caps`. Its break is ignored.
- Byte with `ext`=1: ignored; flags are cleared.
- Byte with `brk`=1 that is not a modifier: ignored.
- Make-code translation:
  - Letters per set-2 table (0x1C a, 0x32 b, 0x21 c, 0x23 d, 0x24 e, 0x2B f, 0x34 g, 0x33 h, 0x43 i, 0x3B j, 0x42 k, 0x4B l, 0x3A m, 0x31 n, 0x44 o, 0x4D p, 0x15 q, 0x2D r, 0x1B s, 0x2C t, 0x3C u, 0x2A v, 0x1D w, 0x22 x, 0x35 y, 0x1A z). Output is uppercase when `shift` XOR `caps` = 1.
  - Digits 0x45,0x16,0x1E,0x26,0x25,0x2E,0x36,0x3D,0x3E,0x46 map to '0'..'9'. Shift does not affect digits.
  - 0x29 maps to 0x20, 0x5A to 0x0D, 0x66 to 0x08.
  - Every other code maps to 0x00, which is never pushed.
- Push when FIFO not full. When full and no pop occurs that cycle: drop the character and set `overflow`. Only `rst` clears `overflow`.
- Pop when `cpu_rd`=1 and not empty. `cpu_rd` on an empty FIFO is ignored.
- Push and pop in the same cycle: both occur, count unchanged. This also applies when full, and in that case nothing is dropped.
- Pointers wrap modulo `FIFO_DEPTH`. The count is `$clog2(FIFO_DEPTH)+1` bits.

## Timing
- Reset values:
  - state IDLE
  - `kb_rdn`=0
  - `brk`=`ext`=`shift`=`caps`=0
  - FIFO emptied: `fifo_empty`=1, `fifo_full`=0, `ascii`=0x00
  - `overflow`=0
- `rst` assertion mid-handshake aborts immediately. A byte left pending in the receiver is taken after release.
- Latency for a translated make code: edge 1 samples `kb_ready`=1; edge 2 in ACK; edge 3 in WAIT; edge 4 in DECODE pushes. `fifo_empty` falls and `ascii` is valid after edge 4.
- `kb_rdn` is registered and high for exactly one cycle per byte.
- `ascii` updates in the cycle after a pop.
- The throughput limit is 1 byte per 4 cycles, far above the PS/2 frame rate.

## Structure
- Shared package `kbd_pkg` holds:
  - state encoding
  - prefix/modifier constants: `SC_EXT`=0xE0, `SC_BRK`=0xF0, `SC_LSHIFT`=0x12, `SC_RSHIFT`=0x59, `SC_CAPS`=0x58
  - the combinational scancode-to-ASCII translation function
- Sub-module `kbd_fifo` (parameterised synchronous FIFO with push, pop, head, empty, full) is instantiated once.

## Test plan
- 0x1C -> `ascii`=0x61 four edges after `kb_ready`. `kb_rdn` pulses once. Popping gives `fifo_empty`=1.
- 0x12, 0x1C, 0xF0, 0x12, 0x1C -> FIFO holds 0x41 then 0x61.
- 0x58, 0xF0, 0x58, 0x1C, 0x16 with shift held -> 0x61 ('a', since `shift` XOR `caps` = 0) then 0x31 ('1', digits unaffected by shift).
- 0xE0, 0x1C and 0xE0, 0xF0, 0x1C -> nothing pushed. A following 0x1C pushes 0x61.
- Nine 0x29 bytes with no reads -> `fifo_full`=1, `overflow`=1, eight 0x20 entries. Push and pop in the same cycle while full keeps the count at 8.
- `rst` low during WAIT -> all outputs at reset values; the next byte decodes normally.
